iterative_shift_controller: RTL

- Multi-cycle shift unit for the RV32I execute stage: performs SLL/SRL/SRA of a data word by a 5-bit (generally log2(nb_bits_data)-bit) amount.
- Sequences a single reusable shift-stage datapath over log2(nb_bits_data) cycles, one power-of-two stage per cycle, MSB of shamt first.
- Uses a start/ready/valid handshake and has fixed latency so the pipeline controller can stall deterministically.
- Supports flush from the hazard unit.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_stage_unit.sv | 47 ++++
 rtl/iterative_shift_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shift unit.
//   shift_op_t         : shift operation encoding carried on op_i
//   shift_ctrl_state_t : controller FSM states
//   SHIFT_LATENCY      : cycles from accept to the valid_o strobe (32-bit datapath)
package shift_pkg;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_ctrl_state_t;

  // One stage per shamt bit plus the accept cycle.
  function automatic int unsigned shift_latency(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned SHIFT_LATENCY = shift_latency(32);

endpackage

// File: rtl/shift_stage_unit.sv
// Combinational single shift stage: shifts data_i by 2**stage_i in the direction
// selected by op_i, or passes data_i through when en_i is low.
//   data_i  : operand
//   op_i    : shift_op_t encoding (reserved op passes through)
//   stage_i : stage index, shift distance is 2**stage_i
//   en_i    : stage enable (the shamt bit for this stage)
//   data_o  : stage result
module shift_stage_unit
  import shift_pkg::*;
#(
  parameter int unsigned nb_bits_data  = 32,
  parameter int unsigned nb_bits_shamt = $clog2(nb_bits_data)
) (
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [1:0]               op_i,
  input  logic [nb_bits_shamt-1:0] stage_i,
  input  logic                     en_i,
  output logic [nb_bits_data-1:0]  data_o
);

  localparam logic [nb_bits_shamt-1:0] One = nb_bits_shamt'(1);

  logic [nb_bits_shamt-1:0] amt;
  logic [nb_bits_data-1:0]  sll_val;
  logic [nb_bits_data-1:0]  srl_val;
  logic [nb_bits_data-1:0]  sign_fill;

  always_comb begin
    // 2**stage_i always fits: the largest stage distance is nb_bits_data/2.
    amt       = One << stage_i;
    sll_val   = data_i << amt;
    srl_val   = data_i >> amt;
    // Ones in exactly the vacated MSB positions when the operand is negative.
    sign_fill = data_i[nb_bits_data-1] ? ~({nb_bits_data{1'b1}} >> amt) : '0;

    data_o = data_i;
    if (en_i) begin
      unique case (shift_op_t'(op_i))
        SLL:     data_o = sll_val;
        SRL:     data_o = srl_val;
        SRA:     data_o = srl_val | sign_fill;
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/iterative_shift_controller.sv
// Multi-cycle SLL/SRL/SRA unit. One shift stage is reused for nb_bits_shamt
// cycles, largest stage first, giving a fixed latency regardless of shamt.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, op_i,
//   data_i, shamt_i     : request, accepted when start_i & ready_o
//   flush_i             : abort the in-flight operation
//   ready_o             : can accept (IDLE or DONE)
//   busy_o              : shifting
//   valid_o             : one-cycle result strobe
//   data_o              : working register; final only when valid_o is high
module iterative_shift_controller
  import shift_pkg::*;
#(
  parameter int unsigned nb_bits_data  = 32,
  parameter int unsigned nb_bits_shamt = $clog2(nb_bits_data)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               op_i,
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shamt-1:0] shamt_i,
  input  logic                     flush_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [nb_bits_data-1:0]  data_o
);

  localparam logic [nb_bits_shamt-1:0] CntTop = nb_bits_shamt'(nb_bits_shamt - 1);

  shift_ctrl_state_t        state_q, state_d;
  logic [nb_bits_shamt-1:0] cnt_q, cnt_d;
  logic [nb_bits_data-1:0]  data_q, data_d;
  shift_op_t                op_q, op_d;
  logic [nb_bits_shamt-1:0] shamt_q, shamt_d;

  logic                     accept;
  logic [nb_bits_data-1:0]  stage_out;

  shift_stage_unit #(
    .nb_bits_data  (nb_bits_data),
    .nb_bits_shamt (nb_bits_shamt)
  ) u_stage (
    .data_i  (data_q),
    .op_i    (op_q),
    .stage_i (cnt_q),
    .en_i    (shamt_q[cnt_q]),
    .data_o  (stage_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // flush_i in IDLE suppresses a coincident start.
        accept = start_i & ~flush_i;
      end
      SHIFT: begin
        if (flush_i) begin
          // Partial result is left in data_q; no strobe for this operation.
          state_d = IDLE;
        end else begin
          data_d = stage_out;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        accept = start_i & ~flush_i;
        if (!accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CntTop;
      data_d  = data_i;
      op_d    = shift_op_t'(op_i);
      shamt_d = shamt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      op_q    <= SLL;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
    end
  end

  always_comb begin
    ready_o = (state_q == IDLE) || (state_q == DONE);
    busy_o  = (state_q == SHIFT);
    valid_o = (state_q == DONE);
    data_o  = data_q;
  end

endmodule
